// File: rtl/simd_warp_core.sv
// simd_warp_core: single-warp SIMD execution core.
// Fetches one instruction at a time over a valid/ready instruction port and
// executes it in lock-step on every active lane. Each lane has a private
// 32-entry register file. LOAD reads a per-lane word from the data port.
// A kernel ends on HALT.
// Optional build macro SIMD_WATCHDOG_EN adds an executed-instruction watchdog.
// When it fires, the kernel is aborted after MAX_INSTR instructions and
// o_timeout is raised alongside o_done.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for i_start, outputs quiet
// S_FETCH     | instruction request presented, waiting for ready
// S_WAIT_I    | waiting for the instruction response
// S_EXEC      | decode; ALU ops write back here, LOAD/HALT branch off
// S_LOAD_REQ  | data request presented, waiting for ready
// S_LOAD_WAIT | waiting for the per-lane load data, then write back
// S_DONE      | one-cycle o_done pulse, then back to idle
module simd_warp_core #(
    parameter int THREADS   = 8,
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int WID_W     = 4,
    parameter int MAX_INSTR = 1024
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [PC_W-1:0]              i_start_pc,
    input  logic [$clog2(THREADS+1)-1:0] i_thread_count,
    input  logic [WID_W-1:0]             i_warp_id,
    output logic                         o_busy,
    output logic                         o_imem_req_valid,
    input  logic                         i_imem_req_ready,
    output logic [PC_W-1:0]              o_imem_req_addr,
    input  logic                         i_imem_rsp_valid,
    input  logic [31:0]                  i_imem_rsp_data,
    output logic                         o_dmem_req_valid,
    input  logic                         i_dmem_req_ready,
    output logic [8:0]                   o_dmem_req_addr,
    input  logic                         i_dmem_rsp_valid,
    input  logic [THREADS*DATA_W-1:0]    i_dmem_rsp_data,
    output logic                         o_done,
    output logic [WID_W-1:0]             o_done_warp_id,
    output logic                         o_timeout,
    output logic [THREADS*DATA_W-1:0]    o_result_out
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_I    = 3'd2,
        S_EXEC      = 3'd3,
        S_LOAD_REQ  = 3'd4,
        S_LOAD_WAIT = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SLL  = 3'b100;
    localparam logic [2:0] OP_SRL  = 3'b101;
    localparam logic [2:0] OP_LOAD = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t                     r_state;
    logic [PC_W-1:0]            r_pc;
    logic [31:0]                r_instr;
    logic [THREADS-1:0]         r_mask;
    logic [WID_W-1:0]           r_wid;
    logic                       r_busy;
    logic                       r_imem_valid;
    logic [PC_W-1:0]            r_imem_addr;
    logic                       r_dmem_valid;
    logic [8:0]                 r_dmem_addr;
    logic                       r_done;
    logic [WID_W-1:0]           r_done_wid;
    logic [THREADS*DATA_W-1:0]  r_result;
    logic [DATA_W-1:0]          r_regs [THREADS][32];

    logic [2:0]                 w_op;
    logic [4:0]                 w_rd, w_rs1, w_rs2, w_shamt, w_sh;
    logic [8:0]                 w_addr;
    logic [THREADS-1:0]         w_mask_in;
    logic [DATA_W-1:0]          w_a     [THREADS];
    logic [DATA_W-1:0]          w_b     [THREADS];
    logic [DATA_W-1:0]          w_alu   [THREADS];
    logic [DATA_W-1:0]          w_wdata [THREADS];
    logic                       w_complete;
    logic                       w_wd_hit;
    logic [PC_W-1:0]            w_pc_next;

    assign w_op      = r_instr[31:29];
    assign w_rd      = r_instr[28:24];
    assign w_rs1     = r_instr[23:19];
    assign w_rs2     = r_instr[18:14];
    assign w_shamt   = r_instr[13:9];
    assign w_addr    = r_instr[8:0];
    assign w_sh      = 5'(32'(w_shamt) % DATA_W);
    assign w_pc_next = r_pc + PC_W'(4);

    // A non-HALT instruction finishes either in EXEC (ALU) or when load data arrives.
    assign w_complete = ((r_state == S_EXEC) && (w_op != OP_LOAD) && (w_op != OP_HALT)) ||
                        ((r_state == S_LOAD_WAIT) && i_dmem_rsp_valid);

`ifdef SIMD_WATCHDOG_EN
    localparam int CNT_W = $clog2(MAX_INSTR + 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_INSTR - 1);
    logic [CNT_W-1:0] r_icnt;
    logic             r_timeout;
    assign w_wd_hit  = (r_icnt >= WD_LAST);
    assign o_timeout = r_timeout;
`else
    assign w_wd_hit  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // Lane enable from the launch-time thread count.
    always_comb begin
        w_mask_in = '0;
        for (int i = 0; i < THREADS; i++) begin
            w_mask_in[i] = (i < int'(i_thread_count));
        end
    end

    // Per-lane operand read (r0 reads as zero), ALU and write-back data select.
    always_comb begin
        for (int i = 0; i < THREADS; i++) begin
            w_a[i] = (w_rs1 == 5'd0) ? '0 : r_regs[i][w_rs1];
            w_b[i] = (w_rs2 == 5'd0) ? '0 : r_regs[i][w_rs2];
            case (w_op)
                OP_ADD:  w_alu[i] = w_a[i] + w_b[i];
                OP_SUB:  w_alu[i] = w_a[i] - w_b[i];
                OP_AND:  w_alu[i] = w_a[i] & w_b[i];
                OP_OR:   w_alu[i] = w_a[i] | w_b[i];
                OP_SLL:  w_alu[i] = w_a[i] << w_sh;
                OP_SRL:  w_alu[i] = w_a[i] >> w_sh;
                default: w_alu[i] = '0;
            endcase
            w_wdata[i] = (r_state == S_EXEC) ? w_alu[i] : i_dmem_rsp_data[i*DATA_W +: DATA_W];
        end
    end

    // Fetch/execute sequencer with registered handshake and completion outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_instr      <= '0;
            r_mask       <= '0;
            r_wid        <= '0;
            r_busy       <= 1'b0;
            r_imem_valid <= 1'b0;
            r_imem_addr  <= '0;
            r_dmem_valid <= 1'b0;
            r_dmem_addr  <= '0;
            r_done       <= 1'b0;
            r_done_wid   <= '1;
            r_result     <= '0;
            for (int t = 0; t < THREADS; t++) begin
                for (int k = 0; k < 32; k++) begin
                    r_regs[t][k] <= '0;
                end
            end
`ifdef SIMD_WATCHDOG_EN
            r_icnt       <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_pc   <= i_start_pc;
                        r_mask <= w_mask_in;
                        r_wid  <= i_warp_id;
                        r_busy <= 1'b1;
`ifdef SIMD_WATCHDOG_EN
                        r_icnt <= '0;
`endif
                        if (i_thread_count == '0) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_done_wid <= i_warp_id;
                        end else begin
                            r_state      <= S_FETCH;
                            r_imem_valid <= 1'b1;
                            r_imem_addr  <= i_start_pc;
                        end
                    end
                end
                S_FETCH: begin
                    if (i_imem_req_ready) begin
                        r_imem_valid <= 1'b0;
                        r_state      <= S_WAIT_I;
                    end
                end
                S_WAIT_I: begin
                    if (i_imem_rsp_valid) begin
                        r_instr <= i_imem_rsp_data;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_op == OP_LOAD) begin
                        r_state      <= S_LOAD_REQ;
                        r_dmem_valid <= 1'b1;
                        r_dmem_addr  <= w_addr;
                    end else if (w_op == OP_HALT) begin
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_done_wid <= r_wid;
`ifdef SIMD_WATCHDOG_EN
                        r_icnt     <= r_icnt + CNT_W'(1);
`endif
                    end
                end
                S_LOAD_REQ: begin
                    if (i_dmem_req_ready) begin
                        r_dmem_valid <= 1'b0;
                        r_state      <= S_LOAD_WAIT;
                    end
                end
                S_LOAD_WAIT: begin
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_done_wid <= '1;
`ifdef SIMD_WATCHDOG_EN
                    r_timeout  <= 1'b0;
`endif
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_complete) begin
                for (int i = 0; i < THREADS; i++) begin
                    if (r_mask[i] && (w_rd != 5'd0)) begin
                        r_regs[i][w_rd]                <= w_wdata[i];
                        r_result[i*DATA_W +: DATA_W]   <= w_wdata[i];
                    end
                end
                r_pc <= w_pc_next;
`ifdef SIMD_WATCHDOG_EN
                r_icnt <= r_icnt + CNT_W'(1);
`endif
                if (w_wd_hit) begin
                    r_state    <= S_DONE;
                    r_done     <= 1'b1;
                    r_done_wid <= r_wid;
`ifdef SIMD_WATCHDOG_EN
                    r_timeout  <= 1'b1;
`endif
                end else begin
                    r_state      <= S_FETCH;
                    r_imem_valid <= 1'b1;
                    r_imem_addr  <= w_pc_next;
                end
            end
        end
    end

    assign o_busy           = r_busy;
    assign o_imem_req_valid = r_imem_valid;
    assign o_imem_req_addr  = r_imem_addr;
    assign o_dmem_req_valid = r_dmem_valid;
    assign o_dmem_req_addr  = r_dmem_addr;
    assign o_done           = r_done;
    assign o_done_warp_id   = r_done_wid;
    assign o_result_out     = r_result;

endmodule

// File: tb/tb_simd_warp_core.sv
// Testbench for simd_warp_core: memory responders with optional stalls and
// spurious responses, and an instruction-level reference model of the kernel.
module tb_simd_warp_core;
    localparam int T    = 8;
    localparam int DW   = 32;
    localparam int MAXI = 16;
`ifdef SIMD_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic          clk, rst, start;
    logic [31:0]   start_pc;
    logic [3:0]    tc, wid;
    logic          busy, imem_valid, imem_ready, imem_rsp_valid;
    logic [31:0]   imem_addr, imem_rsp_data;
    logic          dmem_valid, dmem_ready, dmem_rsp_valid;
    logic [8:0]    dmem_addr;
    logic [T*DW-1:0] dmem_rsp_data, result;
    logic          done, timeout;
    logic [3:0]    done_wid;

    simd_warp_core #(.THREADS(T), .DATA_W(DW), .PC_W(32), .WID_W(4), .MAX_INSTR(MAXI)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_start_pc(start_pc),
        .i_thread_count(tc), .i_warp_id(wid), .o_busy(busy),
        .o_imem_req_valid(imem_valid), .i_imem_req_ready(imem_ready), .o_imem_req_addr(imem_addr),
        .i_imem_rsp_valid(imem_rsp_valid), .i_imem_rsp_data(imem_rsp_data),
        .o_dmem_req_valid(dmem_valid), .i_dmem_req_ready(dmem_ready), .o_dmem_req_addr(dmem_addr),
        .i_dmem_rsp_valid(dmem_rsp_valid), .i_dmem_rsp_data(dmem_rsp_data),
        .o_done(done), .o_done_warp_id(done_wid), .o_timeout(timeout), .o_result_out(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] imem [256];
    logic [31:0] dmem [512][T];
    logic [31:0] m_regs [T][32];
    logic [31:0] m_res  [T];
    int istall_left = 0, istall_each = 0, dstall_left = 0, dstall_each = 0;
    bit junk_en = 1'b0;
    int done_cnt = 0;

    function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                        input int rs2, input int sh, input int ad);
        return {op[2:0], rd[4:0], rs1[4:0], rs2[4:0], sh[4:0], ad[8:0]};
    endfunction

    function automatic logic [255:0] pack_model();
        logic [255:0] v;
        for (int i = 0; i < T; i++) v[i*DW +: DW] = m_res[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < T; i++) begin
            m_res[i] = '0;
            for (int k = 0; k < 32; k++) m_regs[i][k] = '0;
        end
    endtask

    // Runs the kernel instruction by instruction; returns cycle count and abort flag.
    task automatic model_run(input logic [31:0] pc0, input int tcn, output int cyc, output bit to);
        logic [31:0] pc, ins, a, b, v;
        int op, rd, rs1, rs2, sh, cnt;
        bit fin;
        pc = pc0; cnt = 0; fin = (tcn == 0); cyc = 0; to = 1'b0;
        while (!fin) begin
            ins = imem[pc[9:2]];
            op = int'(ins[31:29]); rd = int'(ins[28:24]); rs1 = int'(ins[23:19]);
            rs2 = int'(ins[18:14]); sh = int'(ins[13:9]);
            cnt++;
            cyc += 3 + istall_each;
            if (op == 7) fin = 1'b1;
            else begin
                if (op == 6) cyc += 2 + dstall_each;
                for (int ln = 0; ln < tcn; ln++) begin
                    a = (rs1 == 0) ? 32'd0 : m_regs[ln][rs1];
                    b = (rs2 == 0) ? 32'd0 : m_regs[ln][rs2];
                    case (op)
                        0: v = a + b;
                        1: v = a - b;
                        2: v = a & b;
                        3: v = a | b;
                        4: v = a << (sh % DW);
                        5: v = a >> (sh % DW);
                        default: v = dmem[ins[8:0]][ln];
                    endcase
                    if (rd != 0) begin
                        m_regs[ln][rd] = v;
                        m_res[ln] = v;
                    end
                end
                pc = pc + 32'd4;
                if (WD && cnt >= MAXI) begin to = 1'b1; fin = 1'b1; end
                if (cnt > 1000) fin = 1'b1;
            end
        end
    endtask

    // Instruction memory responder.
    initial begin
        bit pend, held;
        logic [31:0] paddr, hold;
        pend = 0; held = 0; paddr = '0; hold = '0;
        imem_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0; held = 0; imem_rsp_valid = 1'b0; imem_ready = 1'b1;
            end else begin
                if (held) check("imem_hold", {imem_valid, imem_addr}, {1'b1, hold});
                if (pend) begin
                    imem_rsp_valid = 1'b1; imem_rsp_data = imem[paddr[9:2]]; pend = 0;
                end else if (junk_en && $urandom_range(0, 3) == 0) begin
                    imem_rsp_valid = 1'b1; imem_rsp_data = $urandom;
                end else imem_rsp_valid = 1'b0;
                if (imem_valid && istall_left > 0) begin
                    imem_ready = 1'b0; istall_left--; held = 1; hold = imem_addr;
                end else begin
                    imem_ready = 1'b1; held = 0;
                    if (imem_valid) begin pend = 1; paddr = imem_addr; istall_left = istall_each; end
                end
            end
        end
    end

    // Data memory responder.
    initial begin
        bit pend, held;
        logic [8:0] paddr, hold;
        pend = 0; held = 0; paddr = '0; hold = '0;
        dmem_ready = 1'b1; dmem_rsp_valid = 1'b0; dmem_rsp_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0; held = 0; dmem_rsp_valid = 1'b0; dmem_ready = 1'b1;
            end else begin
                if (held) check("dmem_hold", {dmem_valid, dmem_addr}, {1'b1, hold});
                if (pend) begin
                    dmem_rsp_valid = 1'b1;
                    for (int i = 0; i < T; i++) dmem_rsp_data[i*DW +: DW] = dmem[paddr][i];
                    pend = 0;
                end else if (junk_en && $urandom_range(0, 3) == 0) begin
                    dmem_rsp_valid = 1'b1;
                    for (int i = 0; i < T; i++) dmem_rsp_data[i*DW +: DW] = $urandom;
                end else dmem_rsp_valid = 1'b0;
                if (dmem_valid && dstall_left > 0) begin
                    dmem_ready = 1'b0; dstall_left--; held = 1; hold = dmem_addr;
                end else begin
                    dmem_ready = 1'b1; held = 0;
                    if (dmem_valid) begin pend = 1; paddr = dmem_addr; dstall_left = dstall_each; end
                end
            end
        end
    end

    always @(posedge clk) if (done) done_cnt++;

    task automatic launch(input logic [31:0] pc, input int tcn, input logic [3:0] w);
        @(negedge clk);
        start = 1'b1; start_pc = pc; tc = tcn[3:0]; wid = w;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; start_pc = $urandom; wid = 4'($urandom); tc = 4'($urandom_range(0, 8));
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input logic [3:0] exp_wid,
                             input bit exp_to, input bit poke);
        int k, c0;
        bit seen;
        k = 0; c0 = done_cnt; seen = 0;
        while (k < 400) begin
            if (done) begin seen = 1; break; end
            if (poke && k == 4) begin
                start = 1'b1; start_pc = 32'h3F0; wid = ~exp_wid; tc = 4'd1;
            end else start = 1'b0;
            @(posedge clk); @(negedge clk); k++;
        end
        start = 1'b0;
        check({tag, "_seen"}, 256'(seen), 256'(1));
        if (seen) begin
            check({tag, "_lat"}, 256'(k), 256'(exp_lat));
            check({tag, "_wid"}, 256'(done_wid), 256'(exp_wid));
            check({tag, "_to"}, 256'(timeout), 256'(exp_to));
            check({tag, "_busy"}, 256'(busy), 256'(1));
            @(posedge clk); @(negedge clk);
            check({tag, "_post"}, {busy, done, done_wid}, {1'b0, 1'b0, 4'hF});
            check({tag, "_pulses"}, 256'(done_cnt), 256'(c0 + 1));
        end
    endtask

    task automatic run(input string tag, input logic [31:0] pc, input int tcn,
                       input logic [3:0] w, input int extra, input bit poke);
        int cyc;
        bit to;
        model_run(pc, tcn, cyc, to);
        launch(pc, tcn, w);
        if (tcn > 0) check({tag, "_ireq"}, {imem_valid, imem_addr}, {1'b1, pc});
        wait_done(tag, cyc + extra, w, to, poke);
        check({tag, "_res"}, result, pack_model());
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); @(negedge clk); rst = 1'b0;
        model_clear();
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_busy"}, 256'(busy), 256'(0));
        check({tag, "_ireq"}, {imem_valid, imem_addr}, 256'(0));
        check({tag, "_dreq"}, {dmem_valid, dmem_addr}, 256'(0));
        check({tag, "_done"}, {done, timeout, done_wid}, {1'b0, 1'b0, 4'hF});
        check({tag, "_res"}, result, 256'(0));
    endtask

    initial begin
        int c0, k, n, base;
        bit seen;
        rst = 1'b1; start = 1'b0; start_pc = '0; tc = '0; wid = '0;
        for (int i = 0; i < 256; i++) imem[i] = enc(7, 0, 0, 0, 0, 0);
        for (int a = 0; a < 512; a++) for (int i = 0; i < T; i++) dmem[a][i] = $urandom;
        for (int i = 0; i < T; i++) begin dmem[7][i] = 32'd5; dmem[8][i] = 32'd1; end
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst0");
        rst = 1'b0;

        imem[16] = enc(6, 1, 0, 0, 0, 7);
        imem[17] = enc(0, 2, 1, 1, 0, 0);
        imem[18] = enc(7, 0, 0, 0, 0, 0);
        run("kA", 32'h40, 8, 4'd3, 0, 0);
        check("kA_ten", result, {8{32'd10}});

        do_reset();
        run("kA3", 32'h40, 3, 4'd3, 0, 0);
        check("kA3_mask", result, {{5{32'd0}}, {3{32'd10}}});

        imem[32] = enc(6, 1, 0, 0, 0, 8);
        imem[33] = enc(1, 3, 0, 1, 0, 0);
        imem[34] = enc(7, 0, 0, 0, 0, 0);
        run("kSub", 32'h80, 8, 4'd5, 0, 0);
        check("kSub_val", result, {8{32'hFFFFFFFF}});

        imem[48] = enc(4, 4, 1, 0, 4, 0);
        imem[49] = enc(7, 0, 0, 0, 0, 0);
        run("kSll", 32'hC0, 8, 4'd6, 0, 0);
        check("kSll_val", result, {8{32'h10}});

        imem[64] = enc(0, 0, 1, 1, 0, 0);
        imem[65] = enc(7, 0, 0, 0, 0, 0);
        imem[68] = enc(0, 6, 0, 1, 0, 0);
        imem[69] = enc(7, 0, 0, 0, 0, 0);
        run("kR0w", 32'h100, 8, 4'd7, 0, 0);
        check("kR0w_keep", result, {8{32'h10}});
        run("kR0r", 32'h110, 8, 4'd7, 0, 0);
        check("kR0r_val", result, {8{32'h1}});

        istall_left = 4; istall_each = 0;
        run("kStall", 32'h40, 8, 4'd3, 4, 1);
        check("kStall_ten", result, {8{32'd10}});

        run("kZero", 32'h40, 0, 4'd9, 0, 0);

        launch(32'h40, 8, 4'd9);
        seen = 0;
        for (k = 0; k < 20; k++) begin
            if (dmem_valid) begin seen = 1; break; end
            @(posedge clk); @(negedge clk);
        end
        check("rstmid_reach", 256'(seen), 256'(1));
        @(posedge clk); @(negedge clk);
        c0 = done_cnt;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk_reset_vals("rstmid");
        rst = 1'b0;
        model_clear();
        @(posedge clk); @(negedge clk);
        check("rstmid_nodone", 256'(done_cnt), 256'(c0));
        run("kAfter", 32'h40, 8, 4'd2, 0, 0);
        check("kAfter_ten", result, {8{32'd10}});

        junk_en = 1'b1;
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(1, 10);
            base = $urandom_range(0, 255 - 11);
            for (int j = 0; j < n; j++)
                imem[base + j] = enc($urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 7),
                                     $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 511));
            imem[base + n] = enc(7, 0, 0, 0, 0, 0);
            istall_each = $urandom_range(0, 2); istall_left = istall_each;
            dstall_each = $urandom_range(0, 2); dstall_left = dstall_each;
            run($sformatf("rnd%0d", r), 32'(base * 4), $urandom_range(0, 8), 4'($urandom), 0, 1);
        end
        junk_en = 1'b0; istall_each = 0; istall_left = 0; dstall_each = 0; dstall_left = 0;

`ifdef SIMD_WATCHDOG_EN
        for (int j = 0; j < 24; j++) imem[128 + j] = enc(0, 7, 7, 1, 0, 0);
        run("wdog", 32'h200, 8, 4'd6, 0, 1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: got no finish, expected finish before time limit");
        $fatal(1);
    end
endmodule

// File: doc/simd_warp_core.md
# simd_warp_core

Parametrised single-warp SIMD execution core: fetches one instruction per step from instruction memory over a valid/ready handshake, decodes it, and executes it in lock-step across up to `THREADS` lanes, each with a private 32-entry register file. It replaces the fixed-width, free-running-fetch core with an explicit fetch/execute state machine, a load handshake to a per-lane data memory, a HALT-terminated kernel and a per-kernel active-lane mask. It sits between the warp scheduler (kernel launch and completion) and the shared instruction and data memories.

## Interface
- `THREADS`, 8, number of lanes (1–32).
- `DATA_W`, 32, lane data width (≥ 8).
- `PC_W`, 32, program-counter width.
- `WID_W`, 4, warp-id width.
- `MAX_INSTR`, 1024, watchdog instruction limit (used only with `SIMD_WATCHDOG_EN`).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: launch pulse; sampled only in IDLE.
- `start_pc` in PC_W: first instruction address.
- `thread_count` in $clog2(THREADS+1): number of active lanes; lane i is active iff i < thread_count.
- `warp_id` in WID_W: kernel tag, latched on `start`.
- `busy` out 1: high in every state except IDLE.
- `imem_req_valid` out 1, `imem_req_ready` in 1, `imem_req_addr` out PC_W.
- `imem_rsp_valid` in 1, `imem_rsp_data` in 32.
- `dmem_req_valid` out 1, `dmem_req_ready` in 1, `dmem_req_addr` out 9.
- `dmem_rsp_valid` in 1, `dmem_rsp_data` in THREADS*DATA_W: lane i at bits [i*DATA_W +: DATA_W].
- `done` out 1: one-cycle pulse at kernel end.
- `done_warp_id` out WID_W: latched warp id; valid while `done` is high, all-ones otherwise.
- `timeout` out 1: qualifies `done`; 1 = watchdog abort.
- `result_out` out THREADS*DATA_W: lane i holds the last value written by lane i.

## Operation
- Encoding: [31:29] op, [28:24] rd, [23:19] rs1, [18:14] rs2, [13:9] shamt, [8:0] addr.
- Opcodes:
  - 000 ADD, 001 SUB, 010 AND, 011 OR: rd = rs1 op rs2.
  - 100 SLL, 101 SRL (logical): rd = rs1 shifted by shamt mod DATA_W.
  - 110 LOAD: rd = dmem lane word at addr.
  - 111 HALT.
- Arithmetic wraps modulo 2^DATA_W.
- r0 reads as 0, and writes to r0 are discarded. Such writes still do not update `result_out`.
- Inactive lanes never write a register or update `result_out`.
- FSM states: IDLE, FETCH, WAIT_I, EXEC, LOAD_REQ, LOAD_WAIT, DONE.
  - IDLE → FETCH on `start`. On the same edge, latch PC = start_pc, the lane mask and warp_id.
  - If thread_count = 0, IDLE → DONE instead.
  - FETCH: assert `imem_req_valid` with addr = PC. On ready → WAIT_I.
  - WAIT_I: on `imem_rsp_valid`, latch the instruction → EXEC.
  - EXEC, ALU op: write rd in all active lanes, PC += 4 → FETCH.
  - EXEC, LOAD: → LOAD_REQ.
  - EXEC, HALT: → DONE.
  - LOAD_REQ: assert `dmem_req_valid` with addr. On ready → LOAD_WAIT.
  - LOAD_WAIT: on `dmem_rsp_valid`, write rd per active lane, PC += 4 → FETCH.
  - DONE: `done` = 1 for one cycle → IDLE.
- Request valids stay high and addresses stay stable until ready.
- Response valids outside WAIT_I/LOAD_WAIT are ignored.
- `start` while busy is ignored.
- PC wraps modulo 2^PC_W.

## Timing
- Reset values: busy 0, imem/dmem req_valid 0, req addrs 0, done 0, done_warp_id all-ones, timeout 0, result_out all 0, all lane registers 0, state IDLE.
- `rst` mid-kernel returns to IDLE on the next edge with the reset values above. No `done` pulse is produced.
- With zero-wait memories (ready tied high, response one cycle after request):
  - ALU instruction: 3 cycles (FETCH, WAIT_I, EXEC).
  - LOAD: 5 cycles.
  - HALT: 3 cycles, plus 1 for DONE.
- `start` at edge n → `imem_req_valid` high from cycle n+1.
- A written register is readable by the next instruction, because writes complete in EXEC/LOAD_WAIT before the next fetch.
- `result_out` updates on the same edge as the register write.

## Configuration
- `SIMD_WATCHDOG_EN` defined:
  - An executed-instruction counter (counting ALU, LOAD and HALT) clears on `start`.
  - When an instruction that is not HALT completes and the count reaches MAX_INSTR, the core enters DONE with `timeout` = 1 during the `done` pulse.
- Undefined: no counter is built, `timeout` is constant 0, and a kernel without HALT runs indefinitely.

## Test plan
- THREADS=8, thread_count=8, lanes loaded with 5 via LOAD into r1, then ADD r2=r1+r1, HALT → every result_out lane = 10; `done` pulses once with done_warp_id = launched id (3).
- thread_count=3 with the same kernel → lanes 0–2 = 10, lanes 3–7 remain 0.
- SUB r3 = r0 − r1 with r1 = 1 → 0xFFFFFFFF in all active lanes; SLL by shamt=4 of 0x1 → 0x10; ADD writing r0 → r0 still reads 0.
- `imem_req_ready` held low for 4 cycles → `imem_req_valid` and addr stay stable; the kernel completes correctly, 4 cycles later than with zero-wait memory.
- `rst` asserted mid-LOAD_WAIT → next cycle busy = 0 and all outputs at reset values; a new `start` runs cleanly from start_pc.
- `SIMD_WATCHDOG_EN`, MAX_INSTR=16, kernel without HALT → `done` with timeout = 1 after the 16th instruction; `start` during busy has no effect.
